// File: rtl/router_arbiter.sv
// router_arbiter: XY-routing, round-robin switch allocator with wormhole locks for a 3-port crossbar.
// Defining ROUTER_ARB_STATS_EN adds saturating per-output forwarded-flit counters.
module router_arbiter #(
    parameter logic [3:0] ROUTER_X = 4'd0,
    parameter logic [3:0] ROUTER_Y = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        empty_x,
    input  logic        empty_y,
    input  logic        empty_local,
    input  logic [39:0] head_x,
    input  logic [39:0] head_y,
    input  logic [39:0] head_local,
    input  logic        out_ready_x,
    input  logic        out_ready_y,
    input  logic        out_ready_local,
    output logic        rd_en_x,
    output logic        rd_en_y,
    output logic        rd_en_local,
    output logic [1:0]  control_x,
    output logic [1:0]  control_y,
    output logic [1:0]  control_local,
    output logic        lock_x,
    output logic        lock_y,
    output logic        lock_local,
    output logic        err_drop
`ifdef ROUTER_ARB_STATS_EN
    ,
    output logic [15:0] fwd_cnt_x,
    output logic [15:0] fwd_cnt_y,
    output logic [15:0] fwd_cnt_local
`endif
);
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    // Index 0 = x, 1 = y, 2 = local for both inputs and outputs; select code is index + 1.
    logic [39:0] flit [3];
    logic [1:0]  ftype [3];
    logic [1:0]  route [3];
    logic [2:0]  valid;
    logic [2:0]  is_hs;
    logic [2:0]  ready;

    logic [2:0]  busy_q, busy_d;
    logic [1:0]  owner_q [3];
    logic [1:0]  owner_d [3];
    logic [1:0]  ptr_q [3];
    logic [1:0]  ptr_d [3];

    logic [1:0]  ctrl [3];
    logic [2:0]  pop;
    logic [2:0]  fwd;
    logic [2:0]  held;
    logic        drop;
    logic [1:0]  w;
    logic [1:0]  c;
    logic        granted;

    assign flit[0] = head_x;
    assign flit[1] = head_y;
    assign flit[2] = head_local;
    assign valid   = {~empty_local, ~empty_y, ~empty_x};
    assign ready   = {out_ready_local, out_ready_y, out_ready_x};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_in
            assign ftype[gi] = flit[gi][39:38];
            assign is_hs[gi] = ~flit[gi][39];
            assign route[gi] = (flit[gi][37:34] != ROUTER_X) ? 2'd0 :
                               (flit[gi][33:30] != ROUTER_Y) ? 2'd1 : 2'd2;
        end
    endgenerate

    function automatic logic [1:0] rr_pick(input logic [1:0] p, input int k);
        int s;
        s = (int'(p) + k) % 3;
        return s[1:0];
    endfunction

    always_comb begin
        held = '0;
        for (int o = 0; o < 3; o++) begin
            if (busy_q[o]) held[owner_q[o]] = 1'b1;
        end
    end

    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        pop     = '0;
        fwd     = '0;
        drop    = 1'b0;
        w       = 2'd0;
        c       = 2'd0;
        granted = 1'b0;
        for (int o = 0; o < 3; o++) ctrl[o] = 2'b00;
        if (!rst) begin
            for (int o = 0; o < 3; o++) begin
                if (busy_q[o]) begin
                    w = owner_q[o];
                    // A new head at a locked owner breaks the protocol; discard it.
                    if (valid[w] && is_hs[w]) begin
                        pop[w] = 1'b1;
                        drop   = 1'b1;
                    end else if (valid[w] && ready[o]) begin
                        ctrl[o] = w + 2'd1;
                        pop[w]  = 1'b1;
                        fwd[o]  = 1'b1;
                        if (ftype[w] == T_TAIL) busy_d[o] = 1'b0;
                    end
                end else if (ready[o]) begin
                    granted = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        c = rr_pick(ptr_q[o], k);
                        if (!granted && valid[c] && is_hs[c] && !held[c] && route[c] == 2'(o)) begin
                            granted  = 1'b1;
                            ctrl[o]  = c + 2'd1;
                            pop[c]   = 1'b1;
                            fwd[o]   = 1'b1;
                            ptr_d[o] = c;
                            if (ftype[c] == T_HEAD) begin
                                busy_d[o]  = 1'b1;
                                owner_d[o] = c;
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (valid[i] && !is_hs[i] && !held[i]) begin
                    pop[i] = 1'b1;
                    drop   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int o = 0; o < 3; o++) begin
                owner_q[o] <= 2'd0;
                ptr_q[o]   <= 2'd2;
            end
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign control_x     = ctrl[0];
    assign control_y     = ctrl[1];
    assign control_local = ctrl[2];
    assign rd_en_x       = pop[0];
    assign rd_en_y       = pop[1];
    assign rd_en_local   = pop[2];
    assign lock_x        = busy_q[0] & ~rst;
    assign lock_y        = busy_q[1] & ~rst;
    assign lock_local    = busy_q[2] & ~rst;
    assign err_drop      = drop;

`ifdef ROUTER_ARB_STATS_EN
    logic [15:0] cnt_q [3];
    logic [15:0] cnt_d [3];

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            cnt_d[o] = cnt_q[o];
            if (fwd[o] && cnt_q[o] != 16'hFFFF) cnt_d[o] = cnt_q[o] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < 3; o++) begin
            if (rst) cnt_q[o] <= '0;
            else     cnt_q[o] <= cnt_d[o];
        end
    end

    assign fwd_cnt_x     = cnt_q[0];
    assign fwd_cnt_y     = cnt_q[1];
    assign fwd_cnt_local = cnt_q[2];

    logic unused_bits;
    assign unused_bits = ^{head_x[29:0], head_y[29:0], head_local[29:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{head_x[29:0], head_y[29:0], head_local[29:0], fwd};
`endif
endmodule

// File: tb/tb_router_arbiter.sv
// tb_router_arbiter: directed stimulus with FIFO queues, a packet-level reference model
// checked every cycle, and literal expectations for routing, round-robin, locks and drops.
module tb_router_arbiter;
    localparam logic [3:0] RX = 4'd2;
    localparam logic [3:0] RY = 4'd1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        empty_x, empty_y, empty_local;
    logic [39:0] head_x, head_y, head_local;
    logic        out_ready_x, out_ready_y, out_ready_local;
    logic        rd_en_x, rd_en_y, rd_en_local;
    logic [1:0]  control_x, control_y, control_local;
    logic        lock_x, lock_y, lock_local;
    logic        err_drop;
`ifdef ROUTER_ARB_STATS_EN
    logic [15:0] fwd_cnt_x, fwd_cnt_y, fwd_cnt_local;
`endif

    router_arbiter #(.ROUTER_X(RX), .ROUTER_Y(RY)) dut (
        .clk(clk), .rst(rst),
        .empty_x(empty_x), .empty_y(empty_y), .empty_local(empty_local),
        .head_x(head_x), .head_y(head_y), .head_local(head_local),
        .out_ready_x(out_ready_x), .out_ready_y(out_ready_y), .out_ready_local(out_ready_local),
        .rd_en_x(rd_en_x), .rd_en_y(rd_en_y), .rd_en_local(rd_en_local),
        .control_x(control_x), .control_y(control_y), .control_local(control_local),
        .lock_x(lock_x), .lock_y(lock_y), .lock_local(lock_local),
        .err_drop(err_drop)
`ifdef ROUTER_ARB_STATS_EN
        , .fwd_cnt_x(fwd_cnt_x), .fwd_cnt_y(fwd_cnt_y), .fwd_cnt_local(fwd_cnt_local)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [39:0] fq0[$], fq1[$], fq2[$];
    logic [12:0] log_q[$];
    logic [2:0]  rdy = 3'b111;
    int          m_owner[3] = '{-1, -1, -1};
    int          m_last[3]  = '{2, 2, 2};

    function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                       input logic [3:0] dy, input logic [29:0] p);
        return {t, dx, dy, p};
    endfunction

    function automatic int mroute(input logic [39:0] f);
        if (f[37:34] != RX) return 0;
        if (f[33:30] != RY) return 1;
        return 2;
    endfunction

    task automatic push(input int i, input logic [39:0] f);
        case (i)
            0: fq0.push_back(f);
            1: fq1.push_back(f);
            default: fq2.push_back(f);
        endcase
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Snapshot layout: [12:11] cx [10:9] cy [8:7] cl [6:4] rd x,y,l [3:1] lock x,y,l [0] err
    function automatic int fld(input int c, input int lsb, input int w);
        logic [12:0] v;
        v = log_q[c];
        return int'(v >> lsb) & ((1 << w) - 1);
    endfunction

    task automatic step(input bit r);
        logic [39:0] hd[3];
        bit          vld[3];
        int          nown[3], nlast[3], held[3];
        logic [1:0]  ec[3];
        logic [2:0]  ep;
        logic [2:0]  lk;
        logic        ee;
        logic [12:0] got, expv;
        int          w, cc;
        bit          found;
        rst = r;
        vld[0] = fq0.size() != 0; hd[0] = vld[0] ? fq0[0] : 40'h0;
        vld[1] = fq1.size() != 0; hd[1] = vld[1] ? fq1[0] : 40'h0;
        vld[2] = fq2.size() != 0; hd[2] = vld[2] ? fq2[0] : 40'h0;
        empty_x = !vld[0]; empty_y = !vld[1]; empty_local = !vld[2];
        head_x = hd[0]; head_y = hd[1]; head_local = hd[2];
        out_ready_x = rdy[0]; out_ready_y = rdy[1]; out_ready_local = rdy[2];
        #1;
        for (int i = 0; i < 3; i++) begin
            held[i] = 0; ec[i] = 2'b00; nown[i] = m_owner[i]; nlast[i] = m_last[i];
        end
        for (int o = 0; o < 3; o++) if (m_owner[o] >= 0) held[m_owner[o]] = 1;
        ep = 3'b000; ee = 1'b0;
        for (int o = 0; o < 3; o++) lk[o] = !r && (m_owner[o] >= 0);
        if (!r) begin
            for (int o = 0; o < 3; o++) begin
                if (m_owner[o] >= 0) begin
                    w = m_owner[o];
                    if (vld[w] && !hd[w][39]) begin
                        ep[w] = 1'b1; ee = 1'b1;
                    end else if (vld[w] && rdy[o]) begin
                        ec[o] = 2'(w + 1); ep[w] = 1'b1;
                        if (hd[w][39:38] == 2'b11) nown[o] = -1;
                    end
                end else if (rdy[o]) begin
                    found = 0;
                    for (int k = 1; k <= 3; k++) begin
                        cc = (m_last[o] + k) % 3;
                        if (!found && vld[cc] && !hd[cc][39] && held[cc] == 0 && mroute(hd[cc]) == o) begin
                            found = 1; ec[o] = 2'(cc + 1); ep[cc] = 1'b1; nlast[o] = cc;
                            if (hd[cc][39:38] == 2'b01) nown[o] = cc;
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && hd[i][39] && held[i] == 0) begin
                    ep[i] = 1'b1; ee = 1'b1;
                end
            end
        end
        got  = {control_x, control_y, control_local, rd_en_x, rd_en_y, rd_en_local,
                lock_x, lock_y, lock_local, err_drop};
        expv = {ec[0], ec[1], ec[2], ep[0], ep[1], ep[2], lk[0], lk[1], lk[2], ee};
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL cycle%0d outputs: got %h expected %h", cyc, got, expv);
        end
        log_q.push_back(got);
        @(posedge clk);
        for (int o = 0; o < 3; o++) begin
            m_owner[o] = r ? -1 : nown[o];
            m_last[o]  = r ? 2 : nlast[o];
        end
        if (ep[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (ep[1] && fq1.size() > 0) void'(fq1.pop_front());
        if (ep[2] && fq2.size() > 0) void'(fq2.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int c0, c1;
        step(1); step(1);

        // Single-flit XY routing from local
        c0 = cyc;
        push(2, mk(2'b00, 4'd3, 4'd1, 30'h11));
        push(2, mk(2'b00, 4'd2, 4'd0, 30'h12));
        push(2, mk(2'b00, 4'd2, 4'd1, 30'h13));
        repeat (4) step(0);
        chk("route_x", fld(c0, 11, 2), 3);
        chk("route_x_pop", fld(c0, 4, 1), 1);
        chk("route_y", fld(c0 + 1, 9, 2), 3);
        chk("route_local", fld(c0 + 2, 7, 2), 3);

        // Round-robin to local output
        step(1); step(1);
        c0 = cyc;
        for (int k = 0; k < 2; k++) begin
            push(0, mk(2'b00, 4'd2, 4'd1, 30'(k)));
            push(1, mk(2'b00, 4'd2, 4'd1, 30'(k)));
            push(2, mk(2'b00, 4'd2, 4'd1, 30'(k)));
        end
        repeat (7) step(0);
        for (int k = 0; k < 6; k++) chk("rr_seq", fld(c0 + k, 7, 2), (k % 3) + 1);

        // Wormhole lock on output y
        step(1); step(1);
        c0 = cyc;
        push(0, mk(2'b01, 4'd2, 4'd0, 30'h1));
        push(0, mk(2'b10, 4'd0, 4'd0, 30'h2));
        push(0, mk(2'b10, 4'd0, 4'd0, 30'h3));
        push(0, mk(2'b11, 4'd0, 4'd0, 30'h4));
        push(2, mk(2'b01, 4'd2, 4'd0, 30'h5));
        push(2, mk(2'b11, 4'd0, 4'd0, 30'h6));
        repeat (8) step(0);
        for (int k = 0; k < 4; k++) chk("worm_ctrl_x", fld(c0 + k, 9, 2), 1);
        chk("worm_local_wait", fld(c0 + 3, 4, 1), 0);
        chk("worm_local_grant", fld(c0 + 4, 9, 2), 3);
        chk("worm_lock_c1", fld(c0 + 1, 2, 1), 1);
        chk("worm_lock_c3", fld(c0 + 3, 2, 1), 1);
        chk("worm_lock_c4", fld(c0 + 4, 2, 1), 0);
        chk("worm_lock_c6", fld(c0 + 6, 2, 1), 0);

        // Backpressure mid-packet
        step(1); step(1);
        c0 = cyc;
        push(0, mk(2'b01, 4'd2, 4'd0, 30'h7));
        push(0, mk(2'b10, 4'd0, 4'd0, 30'h8));
        push(0, mk(2'b10, 4'd0, 4'd0, 30'h9));
        push(0, mk(2'b11, 4'd0, 4'd0, 30'hA));
        step(0); step(0);
        rdy = 3'b101;
        repeat (3) step(0);
        rdy = 3'b111;
        repeat (3) step(0);
        for (int k = 2; k < 5; k++) begin
            chk("bp_ctrl", fld(c0 + k, 9, 2), 0);
            chk("bp_lock", fld(c0 + k, 2, 1), 1);
            chk("bp_pop", fld(c0 + k, 6, 1), 0);
        end
        chk("bp_resume", fld(c0 + 5, 9, 2), 1);
        chk("bp_tail", fld(c0 + 6, 9, 2), 1);
        chk("bp_unlock", fld(c0 + 7, 2, 1), 0);

        // Reset mid-packet leaves orphans
        step(1); step(1);
        c0 = cyc;
        push(0, mk(2'b01, 4'd2, 4'd0, 30'hB));
        push(0, mk(2'b10, 4'd0, 4'd0, 30'hC));
        step(0); step(0);
        step(1); step(1);
        chk("rst_lock_gated", fld(c0 + 2, 2, 1), 0);
        c1 = cyc;
        push(0, mk(2'b10, 4'd0, 4'd0, 30'hD));
        push(0, mk(2'b11, 4'd0, 4'd0, 30'hE));
        repeat (3) step(0);
        for (int k = 0; k < 2; k++) begin
            chk("orphan_err", fld(c1 + k, 0, 1), 1);
            chk("orphan_pop", fld(c1 + k, 6, 1), 1);
            chk("orphan_ctrl", fld(c1 + k, 7, 6), 0);
        end
        chk("orphan_done", fld(c1 + 2, 0, 1), 0);

        // Mixed traffic with intermittent backpressure
        step(1);
        push(0, mk(2'b01, 4'd2, 4'd1, 30'h20)); push(0, mk(2'b10, 4'd0, 4'd0, 30'h21));
        push(0, mk(2'b11, 4'd0, 4'd0, 30'h22)); push(0, mk(2'b00, 4'd2, 4'd3, 30'h23));
        push(1, mk(2'b01, 4'd2, 4'd1, 30'h30)); push(1, mk(2'b11, 4'd0, 4'd0, 30'h31));
        push(1, mk(2'b00, 4'd0, 4'd1, 30'h32)); push(1, mk(2'b10, 4'd0, 4'd0, 30'h33));
        push(2, mk(2'b00, 4'd2, 4'd1, 30'h40)); push(2, mk(2'b01, 4'd5, 4'd5, 30'h41));
        push(2, mk(2'b10, 4'd0, 4'd0, 30'h42)); push(2, mk(2'b11, 4'd0, 4'd0, 30'h43));
        for (int k = 0; k < 30; k++) begin
            rdy = (k % 4 == 3) ? 3'b010 : ((k % 5 == 1) ? 3'b110 : 3'b111);
            step(0);
        end
        rdy = 3'b111;

`ifdef ROUTER_ARB_STATS_EN
        step(1);
        for (int k = 0; k < 70000; k++) push(2, mk(2'b00, 4'd5, 4'd1, 30'(k)));
        repeat (70002) step(0);
        chk("stats_sat", int'(fwd_cnt_x), 16'hFFFF);
        step(1);
        chk("stats_clear", int'(fwd_cnt_x), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/router_arbiter.md
# router_arbiter

Per-router switch allocator that drives the 2-bit `control_x/control_y/control_local` selects and FIFO pops for the 3-port flit crossbar (x, y, local). It sits between the three input FIFO channels and the registered crossbar. Each cycle it computes XY routes from head flits and runs round-robin arbitration per output. It holds wormhole locks from head flit to tail flit, so the crossbar's selects come from this block and are never hand-driven.

## Interface

Parameters:
- `ROUTER_X`, default 0: this router's 4-bit X coordinate.
- `ROUTER_Y`, default 0: this router's 4-bit Y coordinate.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `empty_x`, `empty_y`, `empty_local` in 1: input FIFO empty flags.
- `head_x`, `head_y`, `head_local` in 40: first-word-fall-through head flit of each input FIFO.
- `out_ready_x`, `out_ready_y`, `out_ready_local` in 1: downstream can accept a flit on that output this cycle.
- `rd_en_x`, `rd_en_y`, `rd_en_local` out 1: pop the input FIFO at this edge.
- `control_x`, `control_y`, `control_local` out 2: crossbar select per output.
  - 00 = none, 01 = from x, 10 = from y, 11 = from local.
- `lock_x`, `lock_y`, `lock_local` out 1: output currently held by an in-flight packet.
- `err_drop` out 1: one-cycle pulse when an orphan flit is discarded.

## Operation

- Flit format: `[39:38]` type, `[37:34]` dest X, `[33:30]` dest Y, `[29:0]` payload.
  - Type encoding: 00 = single (head+tail), 01 = head, 10 = body, 11 = tail.
- A flit is valid when its FIFO's `empty_*` flag is low.
- XY route for head/single flits, in priority order:
  - dest X ≠ `ROUTER_X` → output x;
  - else dest Y ≠ `ROUTER_Y` → output y;
  - else → output local.
  - A route back to the arrival port is legal.
- Per-output state: `IDLE` or `BUSY(owner)`, plus a round-robin pointer holding the last granted input.
- `IDLE` output:
  - Candidates are valid head/single flits routed to this output whose input is not the owner of any `BUSY` output.
  - If `out_ready` is high, grant the first candidate after the pointer, in order x → y → local.
  - On grant: drive `control`, assert that input's `rd_en`, and set the pointer to the winner.
  - A head flit moves the output to `BUSY(winner)`. A single flit leaves it `IDLE`.
- `BUSY(owner)` output:
  - When the owner has a valid body or tail flit and `out_ready` is high, forward it: `control` = owner and `rd_en` for the owner.
  - Forwarding a tail flit returns the output to `IDLE`.
  - A head/single flit at the owner while `BUSY` is a protocol error: the flit is dropped.
- Orphan drop: a valid body/tail flit at an input that owns no output is popped without forwarding. `err_drop` pulses, with all controls for it at 00.
- An input is popped by at most one output per cycle. Only one route per input exists, so no conflict arises.
- No `out_ready` → no grant, no pop. State and pointer are unchanged.

## Timing

- `control_*`, `rd_en_*`, and `err_drop` are combinational from registered state and current inputs.
- Locks and pointers are registered.
- The crossbar captures data at the same edge as the pop, so a flit appears at the crossbar output one cycle after grant.
- Tail forwarded at cycle N → output `IDLE` at N+1. A new head can be granted at N+1, giving back-to-back packets with no bubble.
- Full throughput: one flit per output per cycle while the FIFO is non-empty and `out_ready` is high.
- While `rst` is high: all outputs 0, all outputs `IDLE`, all pointers = local (so x has highest priority next).
- Reset mid-packet: locks are lost. Remaining body/tail flits of that packet are dropped afterward, with one `err_drop` pulse each.
- Empty FIFO while `BUSY`: the lock is held indefinitely and the output idles at `control` = 00.

## Configuration

- Macro `ROUTER_ARB_STATS_EN`.
- Defined: adds outputs `fwd_cnt_x`, `fwd_cnt_y`, `fwd_cnt_local` (16 bits each).
  - Each counts flits forwarded on that output and saturates at 0xFFFF.
  - Each clears on `rst`.
  - Dropped flits are not counted.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan

- Single-flit routing: `ROUTER_X`=2, `ROUTER_Y`=1. Single flits on local with dest (3,1), (2,0), and (2,1) → `control_x`, `control_y`, and `control_local` respectively = 11, each with `rd_en_local` in the same cycle.
- Round-robin: x, y, and local all hold back-to-back single flits to output local, `out_ready_local`=1 → `control_local` sequence 01, 10, 11, 01, … from reset.
- Wormhole lock: x sends head, body, body, tail to output y while local sends a head to y → local waits 4 cycles. `lock_y`=1 throughout the x packet, then local's head is granted the next cycle.
- Backpressure: `out_ready_y`=0 for 3 cycles mid-packet → no `rd_en`, `control_y`=00, and the lock is held. The packet resumes when ready returns high.
- Reset mid-packet: assert `rst` after head+body, then deliver the remaining body and tail → 2 `err_drop` pulses, 2 pops, and all controls 00.
- Stats (with `ROUTER_ARB_STATS_EN`): forward 70000 flits on x → `fwd_cnt_x` = 0xFFFF. Pulse `rst` → 0.
